// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu -- multi-cycle load/store unit in front of a fixed-latency SRAM.
//
// Takes one request at a time over a valid/ready handshake and runs one
// SRAM access, with chip enable held for WAIT_CYCLES+1 cycles. The unit
// steers big-endian byte lanes, optionally sign-extends load data, and
// returns a response over a second valid/ready handshake. Illegal widths
// produce an error response, and so do misaligned offsets when the check is
// compiled in. In both cases SRAM is never touched.
//
// Build option:
//   MEM_ALIGN_CHECK_EN  defined   : misaligned offset -> error response
//                       undefined : offset rounded down to a multiple of
//                                   the width, access proceeds
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/ready    request handshake
//   req_we             1 = store, 0 = load
//   req_addr           byte address
//   req_width          access size in bytes (1, 2, 4, 8)
//   req_signed         sign-extend load data
//   req_data           store data, right-justified
//   resp_valid/ready   response handshake
//   resp_data          load result, right-justified (0 for stores/errors)
//   resp_err           illegal width or misaligned access
//   mem_ce, mem_we     SRAM chip / write enable
//   mem_addr_o         word-aligned SRAM address
//   mem_sel_o          byte-lane enables, bit BYTES-1 = lane 0
//   mem_data_o         write data replicated across lanes
//   mem_data_i         SRAM read data
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_width,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    // Byte-lane enables: w ones starting at lane ofs (lane 0 is the MSB bit).
    function automatic logic [BYTES-1:0] lane_sel(input int unsigned ofs,
                                                  input int unsigned w);
        logic [BYTES-1:0] ones;
        logic [BYTES-1:0] low;
        ones = '1;
        low  = ~(ones << w);
        return low << (BYTES - ofs - w);
    endfunction

    // Low w bytes of d copied into every w-byte group of the word.
    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                    input int unsigned w);
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] piece;
        logic [DATA_W-1:0] rep;
        ones  = '1;
        piece = d & (ones >> (DATA_W - 8 * w));
        rep   = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            // A group starting at lane i has its LSB byte in lane i+w-1.
            if ((i & (w - 1)) == 0)
                rep = rep | (piece << (8 * (BYTES - i - w)));
        end
        return rep;
    endfunction

    // Right-justify lanes ofs..ofs+w-1 and fill the rest with zero or sign.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rd,
                                                  input int unsigned ofs,
                                                  input int unsigned w,
                                                  input logic sgn);
        logic [DATA_W-1:0] ones;
        logic [DATA_W-1:0] shl;
        logic [DATA_W-1:0] low;
        logic [DATA_W-1:0] val;
        ones = '1;
        shl  = rd << (8 * ofs);
        low  = ones >> (DATA_W - 8 * w);
        val  = shl >> (DATA_W - 8 * w);
        if (sgn && shl[DATA_W-1])
            val = val | ~low;
        return val;
    endfunction

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [OFS_W-1:0]  ofs_q;
    logic [3:0]        width_q;
    logic              signed_q;
    logic              we_q;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              mem_ce_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BYTES-1:0]  mem_sel_q;
    logic [DATA_W-1:0] mem_data_q;

    // Request decode
    logic              width_legal;
    logic              misaligned;
    logic              req_bad;
    logic [3:0]        width_m1;
    logic [OFS_W-1:0]  req_ofs;
    logic [OFS_W-1:0]  ofs_d;
    logic [ADDR_W-1:0] addr_aligned;

    always_comb begin
        width_legal = ((req_width == 4'd1) || (req_width == 4'd2) ||
                       (req_width == 4'd4) || (req_width == 4'd8)) &&
                      (32'(req_width) <= BYTES);
        width_m1     = req_width - 4'd1;
        req_ofs      = req_addr[OFS_W-1:0];
        misaligned   = (req_ofs & width_m1[OFS_W-1:0]) != '0;
        // Rounding down only matters when the alignment check is absent.
        ofs_d        = req_ofs & ~width_m1[OFS_W-1:0];
        addr_aligned = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
`ifdef MEM_ALIGN_CHECK_EN
        req_bad      = !width_legal || misaligned;
`else
        req_bad      = !width_legal;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ofs_q        <= '0;
            width_q      <= '0;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_sel_q    <= '0;
            mem_data_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        ofs_q       <= ofs_d;
                        width_q     <= req_width;
                        signed_q    <= req_signed;
                        we_q        <= req_we;
                        if (req_bad) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= '0;
                        end else begin
                            state_q    <= S_ACCESS;
                            cnt_q      <= 4'(WAIT_CYCLES);
                            mem_ce_q   <= 1'b1;
                            mem_we_q   <= req_we;
                            mem_addr_q <= addr_aligned;
                            if (req_we) begin
                                mem_sel_q  <= lane_sel(32'(ofs_d), 32'(req_width));
                                mem_data_q <= replicate(req_data, 32'(req_width));
                            end else begin
                                mem_sel_q  <= '0;
                                mem_data_q <= '0;
                            end
                        end
                    end
                end

                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= we_q ? '0
                                             : extract(mem_data_i, 32'(ofs_q),
                                                       32'(width_q), signed_q);
                        mem_ce_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_sel_q    <= '0;
                        mem_data_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= '0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign mem_ce     = mem_ce_q;
    assign mem_we     = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_sel_o  = mem_sel_q;
    assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-bit instance, WAIT_CYCLES = 1
    logic        req_valid, req_ready, req_we, req_signed;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_width;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_sel_o;

    mem_lsu #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_width(req_width), .req_signed(req_signed),
        .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    // 64-bit instance, WAIT_CYCLES = 2
    logic        q_valid, q_ready, q_we, q_signed;
    logic [31:0] q_addr;
    logic [63:0] q_data;
    logic [3:0]  q_width;
    logic        r_valid, r_ready, r_err;
    logic [63:0] r_data;
    logic        m_ce, m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic [7:0]  m_sel;

    mem_lsu #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(2)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we),
        .req_addr(q_addr), .req_width(q_width), .req_signed(q_signed),
        .req_data(q_data),
        .resp_valid(r_valid), .resp_ready(r_ready),
        .resp_data(r_data), .resp_err(r_err),
        .mem_ce(m_ce), .mem_we(m_we), .mem_addr_o(m_addr),
        .mem_sel_o(m_sel), .mem_data_o(m_wdata), .mem_data_i(m_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request on the 32-bit unit; returns at the falling edge of cycle 1.
    task automatic issue32(input logic we, input logic [31:0] addr,
                           input logic [3:0] width, input logic sgn,
                           input logic [31:0] data);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_width  = width;
        req_signed = sgn;
        req_data   = data;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Run a load on the 32-bit unit and check the response in cycle 3.
    task automatic load32(input string tag, input logic [31:0] addr,
                          input logic [3:0] width, input logic sgn,
                          input logic [31:0] exp);
        issue32(1'b0, addr, width, sgn, 32'h0);
        check({tag, "_ce"}, 64'(mem_ce), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 64'(resp_valid), 64'd1);
        check({tag, "_data"}, 64'(resp_data), 64'(exp));
        @(negedge clk);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_width = '0;
        req_signed = 1'b0; req_data = '0; resp_ready = 1'b1; mem_data_i = '0;
        q_valid = 1'b0; q_we = 1'b0; q_addr = '0; q_width = '0;
        q_signed = 1'b0; q_data = '0; r_ready = 1'b1; m_rdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);
        check("rst_resp_data",  64'(resp_data),  64'd0);
        check("rst_mem_ce",     64'(mem_ce),     64'd0);
        check("rst_mem_we",     64'(mem_we),     64'd0);
        check("rst_mem_addr",   64'(mem_addr_o), 64'd0);
        check("rst_mem_sel",    64'(mem_sel_o),  64'd0);
        check("rst_mem_data",   64'(mem_data_o), 64'd0);
        check("rst64_ready",    64'(q_ready),    64'd1);
        rst = 1'b0;

        // Store byte 0xA5 at 0x102
        issue32(1'b1, 32'h102, 4'd1, 1'b0, 32'h0000_00A5);
        check("sb_c1_ce",   64'(mem_ce),     64'd1);
        check("sb_c1_we",   64'(mem_we),     64'd1);
        check("sb_c1_sel",  64'(mem_sel_o),  64'h2);
        check("sb_c1_data", 64'(mem_data_o), 64'hA5A5A5A5);
        check("sb_c1_addr", 64'(mem_addr_o), 64'h100);
        check("sb_c1_rdy",  64'(req_ready),  64'd0);
        @(negedge clk);
        check("sb_c2_ce",   64'(mem_ce),     64'd1);
        check("sb_c2_sel",  64'(mem_sel_o),  64'h2);
        check("sb_c2_data", 64'(mem_data_o), 64'hA5A5A5A5);
        check("sb_c2_vld",  64'(resp_valid), 64'd0);
        @(negedge clk);
        check("sb_c3_vld",  64'(resp_valid), 64'd1);
        check("sb_c3_err",  64'(resp_err),   64'd0);
        check("sb_c3_data", 64'(resp_data),  64'd0);
        check("sb_c3_ce",   64'(mem_ce),     64'd0);
        check("sb_c3_sel",  64'(mem_sel_o),  64'd0);
        check("sb_c3_wd",   64'(mem_data_o), 64'd0);
        @(negedge clk);
        check("sb_c4_rdy",  64'(req_ready),  64'd1);
        check("sb_c4_vld",  64'(resp_valid), 64'd0);

        // Store half 0xBEEF at 0x102
        issue32(1'b1, 32'h102, 4'd2, 1'b0, 32'h1234_BEEF);
        check("sh_sel",  64'(mem_sel_o),  64'h3);
        check("sh_data", 64'(mem_data_o), 64'hBEEFBEEF);
        repeat (3) @(negedge clk);

        // Loads against a fixed SRAM word
        mem_data_i = 32'h1234_F00D;
        issue32(1'b0, 32'h102, 4'd2, 1'b1, 32'h0);
        check("lh_c1_we",   64'(mem_we),     64'd0);
        check("lh_c1_sel",  64'(mem_sel_o),  64'd0);
        check("lh_c1_data", 64'(mem_data_o), 64'd0);
        check("lh_c1_addr", 64'(mem_addr_o), 64'h100);
        repeat (3) @(negedge clk);
        load32("lhs", 32'h102, 4'd2, 1'b1, 32'hFFFF_F00D);
        load32("lhu", 32'h102, 4'd2, 1'b0, 32'h0000_F00D);
        load32("lbs2", 32'h102, 4'd1, 1'b1, 32'hFFFF_FFF0);
        load32("lbs3", 32'h103, 4'd1, 1'b1, 32'h0000_000D);
        load32("lw",  32'h100, 4'd4, 1'b1, 32'h1234_F00D);

        // Misaligned half at 0x101
`ifdef MEM_ALIGN_CHECK_EN
        issue32(1'b0, 32'h101, 4'd2, 1'b0, 32'h0);
        check("mis_vld", 64'(resp_valid), 64'd1);
        check("mis_err", 64'(resp_err),   64'd1);
        check("mis_ce",  64'(mem_ce),     64'd0);
        @(negedge clk);
        check("mis_rdy", 64'(req_ready),  64'd1);
`else
        load32("mis", 32'h101, 4'd2, 1'b0, 32'h0000_1234);
`endif

        // Width 8 on a 32-bit unit, response held off for 5 cycles
        resp_ready = 1'b0;
        issue32(1'b0, 32'h100, 4'd8, 1'b0, 32'h0);
        check("w8_vld",  64'(resp_valid), 64'd1);
        check("w8_err",  64'(resp_err),   64'd1);
        check("w8_ce",   64'(mem_ce),     64'd0);
        req_valid = 1'b1;   // must be ignored while busy
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w8_hold_vld",  64'(resp_valid), 64'd1);
            check("w8_hold_data", 64'(resp_data),  64'd0);
            check("w8_hold_rdy",  64'(req_ready),  64'd0);
            check("w8_hold_ce",   64'(mem_ce),     64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("w8_rel_vld", 64'(resp_valid), 64'd0);
        check("w8_rel_rdy", 64'(req_ready),  64'd1);

        // Width 3 is illegal
        issue32(1'b0, 32'h100, 4'd3, 1'b0, 32'h0);
        check("w3_err", 64'(resp_err), 64'd1);
        check("w3_ce",  64'(mem_ce),   64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of an access
        issue32(1'b0, 32'h100, 4'd4, 1'b0, 32'h0);
        check("ar_ce_before", 64'(mem_ce), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_ce_after", 64'(mem_ce),    64'd0);
        check("ar_rdy",      64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ar_no_resp", 64'(resp_valid), 64'd0);
        end

        // 64-bit unit: load word at offset 4, signed
        m_rdata = 64'h1122_3344_8899_AABB;
        @(negedge clk);
        q_valid = 1'b1; q_we = 1'b0; q_addr = 32'h204; q_width = 4'd4;
        q_signed = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        check("d64_c1_ce",   64'(m_ce),   64'd1);
        check("d64_c1_addr", 64'(m_addr), 64'h200);
        @(negedge clk);
        @(negedge clk);
        check("d64_c3_ce",  64'(m_ce),    64'd1);
        check("d64_c3_vld", 64'(r_valid), 64'd0);
        @(negedge clk);
        check("d64_c4_vld",  64'(r_valid), 64'd1);
        check("d64_c4_err",  64'(r_err),   64'd0);
        check("d64_c4_data", r_data,       64'hFFFF_FFFF_8899_AABB);
        check("d64_c4_ce",   64'(m_ce),    64'd0);

        // 64-bit unit: store byte 0x5A at offset 7
        @(negedge clk);
        q_valid = 1'b1; q_we = 1'b1; q_addr = 32'h307; q_width = 4'd1;
        q_data = 64'h5A;
        @(negedge clk);
        q_valid = 1'b0;
        check("d64_sb_sel",  64'(m_sel), 64'h01);
        check("d64_sb_data", m_wdata,    64'h5A5A_5A5A_5A5A_5A5A);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised, multi-cycle load/store unit between the switch datapath and the on-board SRAM port. It accepts one request at a time over a valid/ready handshake and drives a fixed-latency SRAM for a configurable number of wait cycles. It performs big-endian byte-lane steering with optional sign extension, and returns a response over a second valid/ready handshake. Illegal or misaligned accesses produce an error response without touching SRAM.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, SRAM data width; 32 or 64; `BYTES = DATA_W/8`, `OFS_W = log2(BYTES)`.
- `WAIT_CYCLES`, 1, extra SRAM cycles per access (0..15); `mem_ce` is held for `WAIT_CYCLES+1` cycles.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and accepting a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W`: byte address.
- `req_width` in 4: access size in bytes: 1, 2, 4 or 8.
- `req_signed` in 1: sign-extend load data.
- `req_data` in `DATA_W`: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_data` out `DATA_W`: load result, right-justified; 0 for stores and errors.
- `resp_err` out 1: illegal width or misaligned access.
- `mem_ce` out 1: SRAM chip enable.
- `mem_we` out 1: SRAM write enable.
- `mem_addr_o` out `ADDR_W`: address with the low `OFS_W` bits cleared.
- `mem_sel_o` out `BYTES`: byte-lane enables; bit `BYTES-1` is lane 0.
- `mem_data_o` out `DATA_W`: write data, replicated across all lanes.
- `mem_data_i` in `DATA_W`: read data.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. `req_ready` = (state == IDLE).
- **IDLE:** a request is accepted when `req_valid && req_ready`. Its fields are registered.
  - Legal request: go to ACCESS and load the wait counter with `WAIT_CYCLES`.
  - Illegal request: go to RESP with `resp_err=1`.
- **Illegal request:**
  - `req_width` is not in {1,2,4,8}, or `req_width > BYTES`.
  - With the alignment check compiled in, `addr[OFS_W-1:0]` is not a multiple of `req_width`.
- **Lane mapping (big-endian):**
  - Offset k = `addr[OFS_W-1:0]` maps to lane k, at bits `[DATA_W-1-8k -: 8]`.
  - A width-w access covers lanes k..k+w-1.
- **ACCESS:**
  - `mem_ce=1`; `mem_we=req_we`; `mem_addr_o` is the aligned address.
  - Store: `mem_sel_o` is one-hot per covered lane; `mem_data_o` = `req_data[8w-1:0]` replicated `BYTES/w` times.
  - Load: `mem_sel_o=0` and `mem_data_o=0`.
  - The counter decrements each cycle.
  - When the counter reaches 0, `mem_data_i` is captured and the unit goes to RESP.
- **Load result:** the covered lanes are right-justified.
  - The upper bits are filled with the lane MSB if `req_signed`, else with 0.
  - For w = `BYTES`, the result is the raw word.
- **RESP:** `resp_valid=1`. The state is held, with all response outputs stable, until `resp_ready`, then the unit returns to IDLE.
- Only one request is in flight at a time; no new request is accepted before the response handshake completes.
- Whenever `mem_ce=0`, `mem_we`, `mem_sel_o` and `mem_data_o` are all 0.

## Timing
- **Reset:** state IDLE.
  - `req_ready=1`.
  - `resp_valid=0`, `resp_err=0`, `resp_data=0`.
  - `mem_ce=0`, `mem_we=0`, `mem_addr_o=0`, `mem_sel_o=0`, `mem_data_o=0`.
  - Reset is asynchronous and aborts any access mid-operation: `mem_ce` drops immediately and no response is issued.
- **Legal access:**
  - Accept at edge 0.
  - `mem_ce` is high from cycle 1 through cycle `WAIT_CYCLES+1`.
  - `mem_data_i` is sampled at the end of cycle `WAIT_CYCLES+1`.
  - `resp_valid` is high from cycle `WAIT_CYCLES+2`.
  - Minimum request-to-request spacing is `WAIT_CYCLES+3` cycles when `resp_ready` is held at 1.
- **Error access:** `resp_valid` is high in cycle 1; no SRAM cycle occurs.
- **Response handshake:** if `resp_ready=1` in the first RESP cycle, `req_ready` is 1 in the next cycle. `req_valid` seen while not ready is ignored.
- All outputs are registered.

## Configuration
- `MEM_ALIGN_CHECK_EN`, defined: a misaligned offset yields an error response with no SRAM access.
- Undefined: the offset is rounded down to a multiple of `req_width` and the access proceeds normally. Only illegal widths produce errors.

## Test plan
- Reset (32-bit, `WAIT_CYCLES=1`): every output is at its reset value. Asserting `rst` during ACCESS drops `mem_ce` in the same cycle, and no response follows.
- Store byte 0xA5 at addr 0x102 (32-bit, `WAIT_CYCLES=1`) -> the following hold for cycles 1-2, and `resp_valid` (with `resp_err=0`) asserts in cycle 3:
  - `mem_sel_o`=4'b0010
  - `mem_data_o`=0xA5A5A5A5
  - `mem_addr_o`=0x100
- Load half at addr 0x102, `mem_data_i`=0x1234F00D:
  - With `req_signed=1`, `resp_data`=0xFFFFF00D.
  - With `req_signed=0`, `resp_data`=0x0000F00D.
- `DATA_W=64`, load word at offset 4, `mem_data_i`=0x11223344_8899AABB, `req_signed=1` -> `resp_data`=0xFFFFFFFF_8899AABB.
- Misaligned load half at addr 0x101:
  - With the macro: `resp_err=1` in cycle 1, and `mem_ce` stays 0.
  - Without the macro: offset 0 is used, and `resp_data` = upper half.
- Width 8 with `DATA_W=32` -> `resp_err=1`. Holding `resp_ready=0` for 5 cycles keeps `resp_valid`/`resp_data` stable and `req_ready=0`.
